copy_array_partition_param: RTL
===============================

Name: copy_array_partition_param

Overview:
- Parametrised successor to the fixed 10-deep, 4-bit array copier. Reads source array M one element per clock through index I and writes destination array N through index J with a write strobe.
- Adds runtime copy modes: straight copy, stable negatives-first partition, stable non-negatives-first partition, and reversed copy. M need not be pre-sorted.
- Adds a negative-element count, a Done flag, and a state output that the bench can monitor after synthesis.
- Sits between a testbench- or RAM-held M array and N array, using the Start/Ack handshake.

Parameters:
- DATA_W, 4, element width; elements are two's-complement signed.
- DEPTH, 10, number of elements in M and in N (DEPTH >= 2).
- IDX_W, $clog2(DEPTH)+1, width of I, J and Neg_count; holds the value DEPTH.

Ports:
- Clk  in  1  system clock, rising edge.
- Resetb  in  1  asynchronous, active-low reset.
- Start  in  1  one-clock start request, sampled only in INI.
- Ack  in  1  one-clock acknowledge, sampled only in DONE.
- Mode  in  2  00 straight, 01 negatives-first, 10 non-negatives-first, 11 reverse. Latched when Start is accepted.
- Ms_of_I  in  DATA_W  M[I], supplied combinationally by the external array.
- I  out  IDX_W  read index into M.
- J  out  IDX_W  write index into N.
- Ns_of_J_Write  out  1  when high, N[J] <= M[I] at the next rising Clk.
- Done  out  1  high while in DONE.
- Neg_count  out  IDX_W  number of negative elements in M; valid in DONE.
- State  out  4  one-hot state: INI=0001, PASS1=0010, PASS2=0100, DONE=1000.

Behaviour:
- Clock and reset: single clock Clk. Asynchronous, active-low reset Resetb.
- Reset values: State=INI, I=0, J=0, Neg_count=0, latched mode=00.
  - Ns_of_J_Write and Done are decoded from state, so both are 0 in reset.
  - Reset asserted mid-operation aborts immediately with no further writes. The N contents are undefined.
- INI:
  - I<=0 (I<=DEPTH-1 if Mode=11), J<=0, Neg_count<=0.
  - Start=1 -> latch Mode, go to PASS1 at the next edge.
- PASS1: one element per clock.
  - neg = Ms_of_I[DATA_W-1].
  - Match rule: mode 00/11 match every element; mode 01 matches neg=1; mode 10 matches neg=0.
  - Ns_of_J_Write = match, combinational in-state. On a write, J<=J+1.
  - neg=1 -> Neg_count<=Neg_count+1, in every mode.
  - I steps +1 (mode 11: -1).
  - Exit on the last element (I==DEPTH-1, or I==0 for mode 11):
    - mode 00/11 -> DONE.
    - J+match==DEPTH -> DONE (pass 2 skipped).
    - otherwise I<=0 and go to PASS2.
- PASS2: same stepping with the complementary match (mode 01: neg=0; mode 10: neg=1). Writes and J increment as in PASS1.
  - Exit -> DONE on whichever comes first: I==DEPTH-1, or a write that makes J reach DEPTH (early exit).
- DONE:
  - Done=1; I and J hold; no writes.
  - Ack=1 -> INI. Start is ignored.
- Ignored inputs:
  - Start outside INI and Ack outside DONE are ignored.
  - Mode changes after acceptance are ignored.
- Stability: ordering within each class is preserved, so both partitions are stable.
- Latency, counted as clocks spent in PASS states:
  - modes 00/11: exactly DEPTH.
  - modes 01/10: DEPTH + (index of the last complementary element + 1), with a maximum of 2*DEPTH.
  - 0 clocks of PASS2 when all elements fall in the first class.
- Width rules:
  - J never exceeds DEPTH.
  - Neg_count ranges from 0 to DEPTH.
  - I never leaves the range 0..DEPTH-1 while Ns_of_J_Write is high.
- N at DONE always holds exactly DEPTH written elements, forming a permutation of M in every mode.

Decomposition:
- Shared package copy_array_pkg holds:
  - state one-hot localparams INI, PASS1, PASS2, DONE;
  - mode codes MODE_STRAIGHT, MODE_NEG_FIRST, MODE_POS_FIRST, MODE_REVERSE.
- One natural sub-module: copy_array_match, a combinational match decoder (element sign, mode, pass -> match). All remaining logic stays in the top block.

Test Plan (DATA_W=4, DEPTH=10; clocks counted from Start accepted to Done rising):
- Mode 01, M={2,5,7,-7,-6,-5,-4,-3,-2,-1} -> N={-7,-6,-5,-4,-3,-2,-1,2,5,7}, Neg_count=7; PASS2 exits at I=2, giving 13 PASS clocks.
- Mode 01, M all negative {-8,-8,-8,-7,-6,-5,-4,-3,-2,-1} -> N=M, Neg_count=10, PASS2 never entered, 10 PASS clocks.
- Mode 10, unsorted M={-1,3,-2,4,0,-8,7,1,-3,6} -> N={3,4,0,7,1,6,-1,-2,-8,-3}, Neg_count=4, stable order checked.
- Mode 00 and mode 11, M={0,1,2,3,4,5,6,7,7,-7}:
  - mode 00 -> N=M;
  - mode 11 -> N[k]=M[9-k];
  - both take 10 PASS clocks with Neg_count=1.
- Handshake: Start pulsed in DONE is ignored; Ack pulsed in PASS1 is ignored; Ack in DONE -> INI at the next edge with I=J=0.
- Resetb driven low during PASS1 at I=4 -> State=0001 and I=J=Neg_count=0 asynchronously; no Ns_of_J_Write after reset.

Source files
------------

// File: rtl/copy_array_pkg.sv
// Shared types for the parametrised array copier: one-hot state encoding and copy mode codes.
package copy_array_pkg;

  typedef enum logic [3:0] {
    INI   = 4'b0001,
    PASS1 = 4'b0010,
    PASS2 = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    MODE_STRAIGHT  = 2'b00,
    MODE_NEG_FIRST = 2'b01,
    MODE_POS_FIRST = 2'b10,
    MODE_REVERSE   = 2'b11
  } mode_t;

  function automatic logic single_pass(input mode_t m);
    return (m == MODE_STRAIGHT) || (m == MODE_REVERSE);
  endfunction

endpackage

// File: rtl/copy_array_match.sv
// Decides whether the current element belongs to the class being written in this pass.
module copy_array_match
  import copy_array_pkg::*;
(
  input  logic  neg,
  input  mode_t mode,
  input  logic  pass2,
  output logic  match
);

  // Pass 2 takes the complementary class, which is a single inversion of the pass-1 rule.
  always_comb begin
    match = 1'b1;
    case (mode)
      MODE_NEG_FIRST: match = neg ^ pass2;
      MODE_POS_FIRST: match = ~neg ^ pass2;
      default:        match = 1'b1;
    endcase
  end

endmodule

// File: rtl/copy_array_partition_param.sv
// Copies M into N one element per clock, either straight, reversed, or as a stable sign partition.
//   state | meaning
//   INI   | idle, I/J/Neg_count preset, waiting for Start
//   PASS1 | scan all of M, write the first class (or every element in straight/reverse)
//   PASS2 | rescan M from 0, write the complementary class until N is full
//   DONE  | N complete, Neg_count valid, waiting for Ack
module copy_array_partition_param
  import copy_array_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 10,
  parameter int IDX_W  = $clog2(DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Resetb,
  input  logic              Start,
  input  logic              Ack,
  input  logic [1:0]        Mode,
  input  logic [DATA_W-1:0] Ms_of_I,
  output logic [IDX_W-1:0]  I,
  output logic [IDX_W-1:0]  J,
  output logic              Ns_of_J_Write,
  output logic              Done,
  output logic [IDX_W-1:0]  Neg_count,
  output logic [3:0]        State
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] FULL = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state, state_nx;
  mode_t            mode_q, mode_nx;
  logic [IDX_W-1:0] i_nx, j_nx, negc_nx;
  logic             neg, match, in_pass, at_last, j_fill;

  assign neg     = Ms_of_I[DATA_W-1];
  assign in_pass = (state == PASS1) || (state == PASS2);
  assign at_last = (state == PASS1 && mode_q == MODE_REVERSE) ? (I == '0) : (I == LAST);
  assign j_fill  = (J + IDX_W'(match)) == FULL;

  copy_array_match u_match (
    .neg   (neg),
    .mode  (mode_q),
    .pass2 (state == PASS2),
    .match (match)
  );

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    i_nx     = I;
    j_nx     = J;
    negc_nx  = Neg_count;
    if (in_pass && match) j_nx = J + ONE;
    case (state)
      INI: begin
        i_nx    = (mode_t'(Mode) == MODE_REVERSE) ? LAST : '0;
        j_nx    = '0;
        negc_nx = '0;
        if (Start) begin
          mode_nx  = mode_t'(Mode);
          state_nx = PASS1;
        end
      end
      PASS1: begin
        if (neg) negc_nx = Neg_count + ONE;
        if (!at_last) begin
          i_nx = (mode_q == MODE_REVERSE) ? I - ONE : I + ONE;
        end else if (single_pass(mode_q) || j_fill) begin
          state_nx = DONE;
        end else begin
          i_nx     = '0;
          state_nx = PASS2;
        end
      end
      PASS2: begin
        // Stop as soon as N is full; the remaining elements all belong to pass 1.
        if (at_last || (match && j_fill)) state_nx = DONE;
        else                              i_nx     = I + ONE;
      end
      DONE: begin
        if (Ack) begin
          state_nx = INI;
          i_nx     = '0;
          j_nx     = '0;
        end
      end
      default: state_nx = INI;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      state     <= INI;
      mode_q    <= MODE_STRAIGHT;
      I         <= '0;
      J         <= '0;
      Neg_count <= '0;
    end else begin
      state     <= state_nx;
      mode_q    <= mode_nx;
      I         <= i_nx;
      J         <= j_nx;
      Neg_count <= negc_nx;
    end
  end

  assign Ns_of_J_Write = in_pass && match;
  assign Done          = (state == DONE);
  assign State         = state;

endmodule
